// File: rtl/writeback_stage_pkg.sv
// Shared widths for the writeback stage and its register file.
// W_OPR: operand/result width, W_RD: register index width, NREG: register count.
// W_CNT: width of the retired-instruction counter.
package writeback_stage_pkg;

    localparam int W_OPR = 32;
    localparam int W_RD  = 5;
    localparam int NREG  = 2 ** W_RD;
    localparam int W_CNT = 32;

endpackage

// File: rtl/regfile_2r1w.sv
// Register file, NREG x W_OPR, two combinational read ports and one write port.
// Latency: reads 0 cycles (old contents during a same-index write), writes land on the rising edge.
// Backpressure: none; a write is taken whenever we is high.
// Ports: clk, reset (sync, active low, clears every entry), we/wa/wd write port,
//        ra0/rd0 and ra1/rd1 read ports.
module regfile_2r1w
    import writeback_stage_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [W_RD-1:0]  wa,
    input  logic [W_OPR-1:0] wd,
    input  logic [W_RD-1:0]  ra0,
    input  logic [W_RD-1:0]  ra1,
    output logic [W_OPR-1:0] rd0,
    output logic [W_OPR-1:0] rd1
);

    logic [W_OPR-1:0] mem [NREG];

    // Every entry is writable, including index 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd0 = mem[ra0];
    assign rd1 = mem[ra1];

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: commits execute results into the register file, counts retired instructions, drives forwarding.
// Latency: writes, counter and fwd_* update on the edge after commit; operand reads are combinational.
// Backpressure: stall_i blocks commit, so a held execute result commits exactly once when stall_i drops.
// Ports: clk, reset (sync, active low); v_i/stall_i/wb_i/wb_r_i/result_i from execute;
//        rd0/rd1 addr/data to decode; fwd_v_o/fwd_r_o/fwd_data_o last committed write; retired_o.
// Option: define WB_BYPASS_EN for write-through reads when a read index matches the write in flight.
module writeback_stage
    import writeback_stage_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             v_i,
    input  logic             stall_i,
    input  logic             wb_i,
    input  logic [W_RD-1:0]  wb_r_i,
    input  logic [W_OPR-1:0] result_i,
    input  logic [W_RD-1:0]  rd0_addr_i,
    input  logic [W_RD-1:0]  rd1_addr_i,
    output logic [W_OPR-1:0] rd0_data_o,
    output logic [W_OPR-1:0] rd1_data_o,
    output logic             fwd_v_o,
    output logic [W_RD-1:0]  fwd_r_o,
    output logic [W_OPR-1:0] fwd_data_o,
    output logic [W_CNT-1:0] retired_o
);

    logic             commit;
    logic             wr_en;
    logic [W_OPR-1:0] arr_rd0;
    logic [W_OPR-1:0] arr_rd1;
    logic [W_CNT-1:0] retired_q;
    logic             fwd_v_q;
    logic [W_RD-1:0]  fwd_r_q;
    logic [W_OPR-1:0] fwd_data_q;

    // reset is folded in so nothing can commit while reset is held.
    assign commit = v_i & ~stall_i & reset;
    assign wr_en  = commit & wb_i;

    regfile_2r1w u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en),
        .wa    (wb_r_i),
        .wd    (result_i),
        .ra0   (rd0_addr_i),
        .ra1   (rd1_addr_i),
        .rd0   (arr_rd0),
        .rd1   (arr_rd1)
    );

    // Counts every commit, with or without a register write; wraps naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            retired_q <= '0;
        end else if (commit) begin
            retired_q <= retired_q + 1'b1;
        end
    end

    // fwd_v pulses for one cycle per write; index/data hold until the next write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fwd_v_q    <= 1'b0;
            fwd_r_q    <= '0;
            fwd_data_q <= '0;
        end else begin
            fwd_v_q <= wr_en;
            if (wr_en) begin
                fwd_r_q    <= wb_r_i;
                fwd_data_q <= result_i;
            end
        end
    end

`ifdef WB_BYPASS_EN
    // Write-through: a read hitting the write in flight sees the new value now.
    assign rd0_data_o = (wr_en && (rd0_addr_i == wb_r_i)) ? result_i : arr_rd0;
    assign rd1_data_o = (wr_en && (rd1_addr_i == wb_r_i)) ? result_i : arr_rd1;
`else
    // Same-cycle hits return the old array value; decode covers that case with fwd_*.
    assign rd0_data_o = arr_rd0;
    assign rd1_data_o = arr_rd1;
`endif

    assign retired_o  = retired_q;
    assign fwd_v_o    = fwd_v_q;
    assign fwd_r_o    = fwd_r_q;
    assign fwd_data_o = fwd_data_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: reset, writes, same-cycle reads, stall, counter wrap, reset during write.
// Inputs change 1 time unit after the rising edge; outputs are checked after inputs settle, away from the edge.
// Expected values are hand-computed constants.
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    logic             clk;
    logic             reset;
    logic             v_i;
    logic             stall_i;
    logic             wb_i;
    logic [W_RD-1:0]  wb_r_i;
    logic [W_OPR-1:0] result_i;
    logic [W_RD-1:0]  rd0_addr_i;
    logic [W_RD-1:0]  rd1_addr_i;
    logic [W_OPR-1:0] rd0_data_o;
    logic [W_OPR-1:0] rd1_data_o;
    logic             fwd_v_o;
    logic [W_RD-1:0]  fwd_r_o;
    logic [W_OPR-1:0] fwd_data_o;
    logic [W_CNT-1:0] retired_o;

    int checks = 0;
    int errors = 0;

    writeback_stage dut (
        .clk        (clk),
        .reset      (reset),
        .v_i        (v_i),
        .stall_i    (stall_i),
        .wb_i       (wb_i),
        .wb_r_i     (wb_r_i),
        .result_i   (result_i),
        .rd0_addr_i (rd0_addr_i),
        .rd1_addr_i (rd1_addr_i),
        .rd0_data_o (rd0_data_o),
        .rd1_data_o (rd1_data_o),
        .fwd_v_o    (fwd_v_o),
        .fwd_r_o    (fwd_r_o),
        .fwd_data_o (fwd_data_o),
        .retired_o  (retired_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then move 1 unit past it before driving/checking.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        v_i      = 1'b0;
        stall_i  = 1'b0;
        wb_i     = 1'b0;
        wb_r_i   = '0;
        result_i = '0;
    endtask

    task automatic test_reset();
        idle();
        reset      = 1'b0;
        rd0_addr_i = '0;
        rd1_addr_i = '0;
        tick();
        tick();
        reset = 1'b1;
        for (int a = 0; a < NREG; a++) begin
            rd0_addr_i = W_RD'(a);
            rd1_addr_i = W_RD'(NREG - 1 - a);
            #1;
            checks++;
            if (rd0_data_o !== 32'h0) begin
                errors++;
                $display("FAIL reset_rd0 addr=%0d got=%h exp=0", a, rd0_data_o);
            end
            checks++;
            if (rd1_data_o !== 32'h0) begin
                errors++;
                $display("FAIL reset_rd1 addr=%0d got=%h exp=0", NREG - 1 - a, rd1_data_o);
            end
        end
        checks++;
        if (retired_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_retired got=%h exp=0", retired_o);
        end
        checks++;
        if (fwd_v_o !== 1'b0 || fwd_r_o !== 5'd0 || fwd_data_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_fwd got=%b/%0d/%h exp=0/0/0", fwd_v_o, fwd_r_o, fwd_data_o);
        end
    endtask

    // Single write of r5 with rd0 reading r5 in the same cycle.
    task automatic test_write();
        logic [W_OPR-1:0] exp_same;
`ifdef WB_BYPASS_EN
        exp_same = 32'hDEADBEEF;
`else
        exp_same = 32'h0;
`endif
        v_i        = 1'b1;
        wb_i       = 1'b1;
        wb_r_i     = 5'd5;
        result_i   = 32'hDEADBEEF;
        rd0_addr_i = 5'd5;
        rd1_addr_i = 5'd6;
        #1;
        checks++;
        if (rd0_data_o !== exp_same) begin
            errors++;
            $display("FAIL same_cycle_rd0 got=%h exp=%h", rd0_data_o, exp_same);
        end
        checks++;
        if (rd1_data_o !== 32'h0) begin
            errors++;
            $display("FAIL same_cycle_rd1_other got=%h exp=0", rd1_data_o);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd0_data_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_r5 got=%h exp=deadbeef", rd0_data_o);
        end
        checks++;
        if (fwd_v_o !== 1'b1 || fwd_r_o !== 5'd5 || fwd_data_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_fwd got=%b/%0d/%h exp=1/5/deadbeef", fwd_v_o, fwd_r_o, fwd_data_o);
        end
        checks++;
        if (retired_o !== 32'd1) begin
            errors++;
            $display("FAIL write_retired got=%0d exp=1", retired_o);
        end
        tick();
        checks++;
        if (fwd_v_o !== 1'b0 || fwd_r_o !== 5'd5 || fwd_data_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL fwd_hold_idle got=%b/%0d/%h exp=0/5/deadbeef", fwd_v_o, fwd_r_o, fwd_data_o);
        end
    endtask

    // wb_i without v_i: nothing happens. v_i without wb_i: count only.
    task automatic test_valid_gating();
        v_i        = 1'b0;
        wb_i       = 1'b1;
        wb_r_i     = 5'd9;
        result_i   = 32'h5555_5555;
        rd1_addr_i = 5'd9;
        tick();
        idle();
        #1;
        checks++;
        if (rd1_data_o !== 32'h0 || retired_o !== 32'd1) begin
            errors++;
            $display("FAIL no_valid got=%h/%0d exp=0/1", rd1_data_o, retired_o);
        end
        v_i        = 1'b1;
        wb_i       = 1'b0;
        wb_r_i     = 5'd10;
        result_i   = 32'h7777_7777;
        rd1_addr_i = 5'd10;
        tick();
        idle();
        #1;
        checks++;
        if (retired_o !== 32'd2) begin
            errors++;
            $display("FAIL count_no_wb got=%0d exp=2", retired_o);
        end
        checks++;
        if (rd1_data_o !== 32'h0) begin
            errors++;
            $display("FAIL no_wb_r10 got=%h exp=0", rd1_data_o);
        end
        checks++;
        if (fwd_v_o !== 1'b0 || fwd_r_o !== 5'd5 || fwd_data_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL fwd_hold_no_wb got=%b/%0d/%h exp=0/5/deadbeef", fwd_v_o, fwd_r_o, fwd_data_o);
        end
    endtask

    // Held result under a 3-cycle stall writes and counts once, when stall drops.
    task automatic test_stall();
        v_i        = 1'b1;
        wb_i       = 1'b1;
        wb_r_i     = 5'd7;
        result_i   = 32'hA5A5_0007;
        stall_i    = 1'b1;
        rd0_addr_i = 5'd7;
        for (int c = 0; c < 3; c++) begin
            tick();
        end
        checks++;
        if (rd0_data_o !== 32'h0 || retired_o !== 32'd2 || fwd_v_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_blocks got=%h/%0d/%b exp=0/2/0", rd0_data_o, retired_o, fwd_v_o);
        end
        stall_i = 1'b0;
        tick();
        idle();
        #1;
        checks++;
        if (rd0_data_o !== 32'hA5A5_0007 || fwd_v_o !== 1'b1 || fwd_r_o !== 5'd7) begin
            errors++;
            $display("FAIL stall_release got=%h/%b/%0d exp=a5a50007/1/7", rd0_data_o, fwd_v_o, fwd_r_o);
        end
        checks++;
        if (retired_o !== 32'd3) begin
            errors++;
            $display("FAIL stall_count got=%0d exp=3", retired_o);
        end
        tick();
        checks++;
        if (retired_o !== 32'd3) begin
            errors++;
            $display("FAIL stall_count_after got=%0d exp=3", retired_o);
        end
    endtask

    // r0 is an ordinary register; also rd1 same-cycle behaviour.
    task automatic test_r0_write();
        logic [W_OPR-1:0] exp_same;
`ifdef WB_BYPASS_EN
        exp_same = 32'h0000_CAFE;
`else
        exp_same = 32'h0;
`endif
        v_i        = 1'b1;
        wb_i       = 1'b1;
        wb_r_i     = 5'd0;
        result_i   = 32'h0000_CAFE;
        rd0_addr_i = 5'd5;
        rd1_addr_i = 5'd0;
        #1;
        checks++;
        if (rd1_data_o !== exp_same) begin
            errors++;
            $display("FAIL same_cycle_rd1 got=%h exp=%h", rd1_data_o, exp_same);
        end
        checks++;
        if (rd0_data_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL same_cycle_rd0_other got=%h exp=deadbeef", rd0_data_o);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd1_data_o !== 32'h0000_CAFE || retired_o !== 32'd4) begin
            errors++;
            $display("FAIL r0_write got=%h/%0d exp=0000cafe/4", rd1_data_o, retired_o);
        end
    endtask

    task automatic test_wrap();
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        #1;
        checks++;
        if (retired_o !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_preload got=%h exp=ffffffff", retired_o);
        end
        v_i  = 1'b1;
        wb_i = 1'b0;
        tick();
        idle();
        #1;
        checks++;
        if (retired_o !== 32'h0) begin
            errors++;
            $display("FAIL wrap got=%h exp=0", retired_o);
        end
    endtask

    task automatic test_reset_during_write();
        v_i        = 1'b1;
        wb_i       = 1'b1;
        wb_r_i     = 5'd3;
        result_i   = 32'h0000_1234;
        reset      = 1'b0;
        rd0_addr_i = 5'd3;
        rd1_addr_i = 5'd5;
        tick();
        idle();
        reset = 1'b1;
        #1;
        checks++;
        if (rd0_data_o !== 32'h0 || rd1_data_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_write_regs got=%h/%h exp=0/0", rd0_data_o, rd1_data_o);
        end
        checks++;
        if (retired_o !== 32'h0 || fwd_v_o !== 1'b0 || fwd_data_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_write_state got=%0d/%b/%h exp=0/0/0", retired_o, fwd_v_o, fwd_data_o);
        end
        v_i      = 1'b1;
        wb_i     = 1'b1;
        wb_r_i   = 5'd3;
        result_i = 32'h0000_0042;
        tick();
        idle();
        #1;
        checks++;
        if (rd0_data_o !== 32'h42 || retired_o !== 32'd1 || fwd_r_o !== 5'd3) begin
            errors++;
            $display("FAIL post_rst_commit got=%h/%0d/%0d exp=42/1/3", rd0_data_o, retired_o, fwd_r_o);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_valid_gating();
        test_stall();
        test_r0_write();
        test_wrap();
        test_reset_during_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter: W_OPR, 32, operand/result width.
REQ-002 Parameter: W_RD, 5, register index width; register count NREG = 2**W_RD = 32.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset, with ports as listed below.
REQ-004 Port: clk  in  1  clock; all state changes on the rising edge.
REQ-005 Port: reset  in  1  synchronous active-low reset.
REQ-006 Port: v_i  in  1  execute-stage result valid.
REQ-007 Port: stall_i  in  1  pipeline stall; when high, the execute outputs are a held repeat.
REQ-008 Port: wb_i  in  1  the execute result targets a register.
REQ-009 Port: wb_r_i  in  W_RD  destination register index.
REQ-010 Port: result_i  in  W_OPR  execute-stage result, including load data.
REQ-011 Port: rd0_addr_i, rd1_addr_i  in  W_RD each  operand read addresses from the decode stage.
REQ-012 Port: rd0_data_o, rd1_data_o  out  W_OPR each  operand read data.
REQ-013 Port: fwd_v_o  out  1  a write was committed on the previous edge.
REQ-014 Port: fwd_r_o  out  W_RD  index of the last committed write.
REQ-015 Port: fwd_data_o  out  W_OPR  data of the last committed write.
REQ-016 Port: retired_o  out  32  count of committed valid instructions.

Function
REQ-017 Commit condition: commit = v_i & ~stall_i & reset.
- A write occurs when commit & wb_i.
- A committed write updates regfile[wb_r_i] <= result_i on the rising edge.
REQ-018 All 32 registers SHALL be writable; r0 is not hardwired.
REQ-019 Reads SHALL be combinational from the array; rdN_data_o = regfile[rdN_addr_i] with zero added latency.
REQ-020 Writes SHALL not be accepted while stall_i is high, so a held execute result writes and counts exactly once, on the cycle stall_i drops.
REQ-021 retired_o SHALL increment by 1 per commit, whether or not wb_i is set, and wrap from 0xFFFF_FFFF to 0.
REQ-022 Forwarding registers SHALL load from the same commit:
- fwd_v_o <= commit & wb_i
- fwd_r_o and fwd_data_o <= wb_r_i and result_i only when that write occurs
- otherwise fwd_r_o and fwd_data_o hold their values.
REQ-023 While reset is low, no write or count SHALL occur, even if a write is presented.
REQ-024 Read and write to the same index in the same cycle SHALL follow REQ-029/REQ-030.
REQ-025 v_i low with wb_i high SHALL cause no write and no count.

Reset
REQ-026 On a rising edge with reset low, the block SHALL clear:
- all 32 registers to 0
- retired_o to 0
- fwd_v_o, fwd_r_o and fwd_data_o to 0.
REQ-027 Reset asserted mid-stall or mid-write SHALL discard the pending write; the first commit after release behaves as from a clean state.
REQ-028 rdN_data_o SHALL read 0 for every address in the cycle after reset.

Configuration
REQ-029 With macro WB_BYPASS_EN defined, when a write occurs and rdN_addr_i == wb_r_i, rdN_data_o SHALL return result_i in that same cycle (write-through).
REQ-030 Without WB_BYPASS_EN, rdN_data_o SHALL return the old array value in that case; the new value is visible the following cycle. Decode relies on fwd_* for this case.

Structure
REQ-031 W_OPR, W_RD and NREG SHALL come from the shared params include; no local redefinition.
REQ-032 The register array with its two read ports and one write port SHALL be a sub-module named regfile_2r1w; writeback_stage holds the commit logic, counter, forwarding registers and bypass muxes.
REQ-033 The RTL scope is 120-400 lines in total.

Verification
REQ-034 Reset low for 2 cycles, then high -> every rd0/rd1 address reads 0; retired_o = 0; fwd_v_o = 0.
REQ-035 v_i=1, wb_i=1, wb_r_i=5, result_i=0xDEADBEEF, one cycle -> next cycle regfile[5] reads 0xDEADBEEF; fwd_v_o=1; fwd_r_o=5; retired_o=1.
REQ-036 Same write with rd0_addr_i=5 in the write cycle -> rd0_data_o=0xDEADBEEF with WB_BYPASS_EN; the old value 0 without it.
REQ-037 stall_i high for 3 cycles with v_i=1, wb_i=1, wb_r_i=7, then low -> exactly one write of r7; retired_o increments by 1 only.
REQ-038 retired_o preloaded to 0xFFFF_FFFF via 2^32-1 commits (or a forced value), then one commit -> retired_o = 0.
REQ-039 Reset driven low in the same cycle as a write to r3=0x1234 -> r3 reads 0 after reset; retired_o = 0.
